prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 30 +++
 rtl/prog_loader_uart_rx_byte.sv | 123 ++++++++++++
 rtl/prog_loader.sv | 161 ++++++++++++++++
 tb/tb_prog_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and state types for the serial program loader.
package prog_loader_pkg;

  // Frame header that opens every program download
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Number of data bytes per frame, one per program RAM word
  localparam int FRAME_LEN = 16;

  // Byte receiver states
  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  // Frame parser states
  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_SUM
  } frame_state_t;

  // Running frame checksum: plain 8-bit sum, carries discarded
  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, bit timer and byte FSM.
// Outputs are registered single-cycle pulses; data stays valid until the
// next byte starts shifting in.
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_ok,
  output logic       frame_err,
  output logic [7:0] data,
  output logic       start_seen
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  // The synchronizer plus edge detector already eat about one cycle, so the
  // start-bit sample is taken one count early to land mid-bit.
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic rx_meta, rx_sync, rx_prev;

  byte_state_t state, state_next;
  logic [CW-1:0] bit_cnt, bit_cnt_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic [7:0] shift, shift_next;
  logic byte_ok_next, frame_err_next, start_seen_next;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Byte FSM state, bit timer, shift register and registered status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= B_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_ok    <= 1'b0;
      frame_err  <= 1'b0;
      start_seen <= 1'b0;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      bit_idx    <= bit_idx_next;
      shift      <= shift_next;
      byte_ok    <= byte_ok_next;
      frame_err  <= frame_err_next;
      start_seen <= start_seen_next;
    end
  end

  // Next-state logic: find the start edge, confirm it mid-bit, shift in
  // eight bits LSB first, then judge the stop bit
  always_comb begin
    state_next      = state;
    bit_cnt_next    = bit_cnt;
    bit_idx_next    = bit_idx;
    shift_next      = shift;
    byte_ok_next    = 1'b0;
    frame_err_next  = 1'b0;
    start_seen_next = 1'b0;
    case (state)
      B_IDLE: begin
        bit_cnt_next = '0;
        if (rx_prev && !rx_sync) begin
          state_next      = B_START;
          start_seen_next = 1'b1;
        end
      end
      B_START: begin
        if (bit_cnt == HALF_M1) begin
          bit_cnt_next = '0;
          if (rx_sync) begin
            state_next = B_IDLE;
          end else begin
            state_next   = B_DATA;
            bit_idx_next = '0;
          end
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
        end
      end
      B_DATA: begin
        if (bit_cnt == FULL_M1) begin
          bit_cnt_next = '0;
          shift_next   = {rx_sync, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = B_STOP;
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
        end
      end
      B_STOP: begin
        if (bit_cnt == FULL_M1) begin
          bit_cnt_next = '0;
          state_next   = B_IDLE;
          if (rx_sync) byte_ok_next = 1'b1;
          else         frame_err_next = 1'b1;
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
        end
      end
      default: state_next = B_IDLE;
    endcase
  end

  assign data = shift;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: parses A5-headed frames from the UART receiver and
// writes the 16 data bytes into the CPU program RAM, holding the CPU while
// a frame is in flight.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLK_HZ       = 27000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       hold,
  output logic       done,
  output logic       err
);

  // The counter restarts on byte_ok (one cycle after the stop sample) and the
  // abort lands one cycle after the limit, so two cycles are taken off to keep
  // err within the full silence budget measured from the stop sample.
  localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT - 2;
  localparam int TW = $clog2(TMO_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TMO_CYCLES);
  localparam logic [3:0] LAST_ADDR = 4'(FRAME_LEN - 1);

  logic       rx_byte_ok, rx_frame_err, rx_start_seen;
  logic [7:0] rx_data;

  frame_state_t state, state_next;
  logic [3:0]    addr_cnt;
  logic [7:0]    sum_acc;
  logic [TW-1:0] tmo_cnt;
  logic          timed_out;
  logic          start_frame, do_write, do_done, do_fail;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_ok   (rx_byte_ok),
    .frame_err (rx_frame_err),
    .data      (rx_data),
    .start_seen(rx_start_seen)
  );

  assign timed_out = (tmo_cnt == TMO_LIMIT);

  // Frame FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= F_IDLE;
    else     state <= state_next;
  end

  // Frame FSM next state and one-cycle action strobes
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    do_write    = 1'b0;
    do_done     = 1'b0;
    do_fail     = 1'b0;
    case (state)
      F_IDLE: begin
        if (rx_byte_ok && rx_data == HDR_BYTE) begin
          start_frame = 1'b1;
          state_next  = F_DATA;
        end
      end
      F_DATA: begin
        if (rx_frame_err || timed_out) begin
          do_fail    = 1'b1;
          state_next = F_IDLE;
        end else if (rx_byte_ok) begin
          do_write = 1'b1;
          if (addr_cnt == LAST_ADDR) state_next = F_SUM;
        end
      end
      F_SUM: begin
        if (rx_frame_err || timed_out) begin
          do_fail    = 1'b1;
          state_next = F_IDLE;
        end else if (rx_byte_ok) begin
          if (rx_data == sum_acc) do_done = 1'b1;
          else                    do_fail = 1'b1;
          state_next = F_IDLE;
        end
      end
      default: state_next = F_IDLE;
    endcase
  end

  // Address counter and checksum accumulator, restarted by each header
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= '0;
      sum_acc  <= '0;
    end else if (start_frame) begin
      addr_cnt <= '0;
      sum_acc  <= '0;
    end else if (do_write) begin
      addr_cnt <= addr_cnt + 4'd1;
      sum_acc  <= sum_add(sum_acc, rx_data);
    end
  end

  // Inter-byte silence timer: idle outside a frame, restarted by any stop
  // sample or start edge, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state_next == F_IDLE) begin
      tmo_cnt <= '0;
    end else if (rx_byte_ok || rx_frame_err || rx_start_seen) begin
      tmo_cnt <= '0;
    end else if (!timed_out) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // RAM write port registers: strobe for one cycle, address/data held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_addr <= addr_cnt;
        wr_data <= rx_data;
      end
    end
  end

  // Status registers: hold spans the frame, done pulses, err is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= do_done;
      if (start_frame) begin
        hold <= 1'b1;
        err  <= 1'b0;
      end else if (do_done) begin
        hold <= 1'b0;
      end else if (do_fail) begin
        hold <= 1'b0;
        err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: drives UART bytes and checks RAM writes and
// status against a byte-level model of the frame protocol.
module tb_prog_loader;

  localparam int CPB      = 16;
  localparam int TMO_BITS = 32;

  typedef struct {
    logic [7:0] value;
    bit         stop_ok;
    int         gap_bits;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       hold;
  logic       done;
  logic       err;

  item_t       stim_q[$];
  logic [11:0] exp_writes[$];
  logic [11:0] got_writes[$];
  int          exp_done, got_done;
  bit          m_in_frame, m_err;
  int          m_idx;
  logic [7:0]  m_sum;
  int          num_checks, num_fails;

  prog_loader #(
    .CLK_HZ      (1600000),
    .BAUD        (100000),
    .TIMEOUT_BITS(TMO_BITS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .hold   (hold),
    .done   (done),
    .err    (err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: record every RAM write and done pulse, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        got_writes.push_back({wr_addr, wr_data});
        checkOutput("hold_at_write", 32'(hold), 32'd1);
      end
      if (done) got_done++;
    end
  end

  // Reference model: protocol rules applied one whole byte at a time
  task automatic model_byte(input logic [7:0] v, input bit stop_ok);
    if (!stop_ok) begin
      if (m_in_frame) begin
        m_in_frame = 1'b0;
        m_err      = 1'b1;
      end
    end else if (!m_in_frame) begin
      if (v == 8'hA5) begin
        m_in_frame = 1'b1;
        m_idx      = 0;
        m_sum      = 8'h00;
        m_err      = 1'b0;
      end
    end else if (m_idx < 16) begin
      exp_writes.push_back({4'(m_idx), v});
      m_sum = m_sum + v;
      m_idx++;
    end else begin
      if (v == m_sum) exp_done++;
      else            m_err = 1'b1;
      m_in_frame = 1'b0;
    end
  endtask

  task automatic model_gap(input int gap_bits);
    if (m_in_frame && gap_bits >= TMO_BITS + 2) begin
      m_in_frame = 1'b0;
      m_err      = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit stop_ok);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      wait_cycles(CPB);
    end
    rx = stop_ok;
    wait_cycles(CPB);
    rx = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] v, input bit stop_ok, input int gap_bits);
    item_t it;
    it.value    = v;
    it.stop_ok  = stop_ok;
    it.gap_bits = gap_bits;
    stim_q.push_back(it);
  endtask

  // mode 0: 00..0F, mode 1: all 11, otherwise random bytes
  task automatic push_frame(input int mode, input bit bad_sum, input bit rand_gaps);
    logic [7:0] d;
    logic [7:0] s;
    s = 8'h00;
    push_byte(8'hA5, 1'b1, 1);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0:       d = 8'(i);
        1:       d = 8'h11;
        default: d = 8'($urandom);
      endcase
      s = s + d;
      push_byte(d, 1'b1, rand_gaps ? int'($urandom_range(1, 3)) : 1);
    end
    push_byte(bad_sum ? s - 8'h10 : s, 1'b1, 1);
  endtask

  // Send every queued item, updating the model and checking status after each
  task automatic applyStimulus();
    item_t it;
    bit    was_in;
    while (stim_q.size() > 0) begin
      it = stim_q.pop_front();
      model_byte(it.value, it.stop_ok);
      send_byte(it.value, it.stop_ok);
      was_in = m_in_frame;
      if (was_in && it.gap_bits >= TMO_BITS + 2) begin
        wait_cycles((TMO_BITS - 3) * CPB);
        checkOutput("no_early_timeout", 32'(hold), 32'd1);
        wait_cycles((it.gap_bits - TMO_BITS + 3) * CPB);
      end else begin
        wait_cycles(it.gap_bits * CPB);
      end
      model_gap(it.gap_bits);
      checkOutput("hold", 32'(hold), 32'(m_in_frame));
      checkOutput("err", 32'(err), 32'(m_err));
    end
  endtask

  task automatic end_scenario(input string name);
    int n;
    wait_cycles(4 * CPB);
    checkOutput($sformatf("%s/write_count", name), 32'(got_writes.size()), 32'(exp_writes.size()));
    n = (got_writes.size() < exp_writes.size()) ? got_writes.size() : exp_writes.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s/write%0d", name, i), 32'(got_writes[i]), 32'(exp_writes[i]));
    checkOutput($sformatf("%s/done_count", name), 32'(got_done), 32'(exp_done));
    checkOutput($sformatf("%s/err", name), 32'(err), 32'(m_err));
    checkOutput($sformatf("%s/hold", name), 32'(hold), 32'(m_in_frame));
    got_writes.delete();
    exp_writes.delete();
    got_done = 0;
    exp_done = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    checkOutput($sformatf("%s/wr_en", name), 32'(wr_en), 32'd0);
    checkOutput($sformatf("%s/wr_addr", name), 32'(wr_addr), 32'd0);
    checkOutput($sformatf("%s/wr_data", name), 32'(wr_data), 32'd0);
    checkOutput($sformatf("%s/hold", name), 32'(hold), 32'd0);
    checkOutput($sformatf("%s/done", name), 32'(done), 32'd0);
    checkOutput($sformatf("%s/err", name), 32'(err), 32'd0);
  endtask

  // Safety net against a stuck run
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    num_checks = 0;
    num_fails  = 0;
    got_done   = 0;
    exp_done   = 0;
    m_in_frame = 1'b0;
    m_err      = 1'b0;
    m_idx      = 0;
    m_sum      = 8'h00;
    rx         = 1'b1;
    rst        = 1'b1;
    wait_cycles(5);
    check_reset_outputs("por");
    rst = 1'b0;
    wait_cycles(2 * CPB);

    $display("[TB] good frame");
    push_frame(0, 1'b0, 1'b0);
    applyStimulus();
    end_scenario("good");

    $display("[TB] bad checksum");
    push_frame(1, 1'b1, 1'b0);
    applyStimulus();
    end_scenario("badsum");

    $display("[TB] noise before header");
    push_byte(8'h3C, 1'b1, 1);
    push_byte(8'hFF, 1'b1, 1);
    applyStimulus();
    rx = 1'b0;
    wait_cycles(5);
    rx = 1'b1;
    wait_cycles(2 * CPB);
    push_frame(0, 1'b0, 1'b0);
    applyStimulus();
    end_scenario("noise");

    $display("[TB] timeout");
    push_byte(8'hA5, 1'b1, 1);
    for (int i = 0; i < 4; i++)
      push_byte(8'(8'h20 + i), 1'b1, (i == 3) ? 40 : 1);
    applyStimulus();
    end_scenario("timeout");

    $display("[TB] framing error");
    push_byte(8'hA5, 1'b1, 1);
    for (int i = 0; i < 16; i++)
      push_byte(8'(8'h40 + i), (i != 5), 1);
    push_byte(8'h55, 1'b1, 1);
    applyStimulus();
    end_scenario("framing");

    $display("[TB] reset mid-frame");
    push_byte(8'hA5, 1'b1, 1);
    for (int i = 0; i < 8; i++)
      push_byte(8'(8'h60 + i), 1'b1, 1);
    applyStimulus();
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    m_in_frame = 1'b0;
    m_err      = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2 * CPB);
    push_frame(0, 1'b0, 1'b0);
    applyStimulus();
    end_scenario("midrst");

    $display("[TB] random frames");
    for (int r = 0; r < 6; r++) begin
      int noise_n;
      logic [7:0] nb;
      noise_n = int'($urandom_range(0, 2));
      for (int k = 0; k < noise_n; k++) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        push_byte(nb, 1'b1, int'($urandom_range(1, 3)));
      end
      push_frame(2, ($urandom_range(0, 3) == 0), 1'b1);
      applyStimulus();
      end_scenario($sformatf("rand%0d", r));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
